// File: rtl/md_pkg.sv
// Shared encodings and constants for the HI/LO multiply/divide sequencer.
package md_pkg;

    localparam int unsigned MD_DATA_W          = 32;
    localparam int unsigned MD_OP_W            = 2;
    localparam int unsigned MD_CNT_W           = 4;
    localparam int unsigned MD_MULT_CYCLES_DEF = 5;
    localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

    typedef enum logic [MD_OP_W-1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    // Operand/operation bundle latched when an operation is accepted.
    typedef struct packed {
        logic [MD_DATA_W-1:0] a;
        logic [MD_DATA_W-1:0] b;
        md_op_e               op;
    } md_req_t;

    function automatic logic md_is_div(input logic [MD_OP_W-1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/md_lat_cnt.sv
// 4-bit loadable down-counter that models the MD unit's fixed latency.
module md_lat_cnt
    import md_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                i_load,
    input  logic [MD_CNT_W-1:0] i_load_val,
    input  logic                i_dec,
    output logic                o_zero
);

    logic [MD_CNT_W-1:0] r_cnt;

    // Load wins over decrement; the count saturates at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - MD_CNT_W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/md_ctrl.sv
// Multi-cycle sequencer for the HI/LO multiply/divide unit.
// Optional MD_DIV0_SKIP_EN: div/divu by zero is not started and commits nothing.
module md_ctrl
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [MD_OP_W-1:0]   op,
    input  logic                 mt_hi,
    input  logic                 mt_lo,
    input  logic [MD_DATA_W-1:0] a_in,
    input  logic [MD_DATA_W-1:0] b_in,
    input  logic                 d_md_use,
    output logic [MD_DATA_W-1:0] a_out,
    output logic [MD_DATA_W-1:0] b_out,
    output logic [MD_OP_W-1:0]   md_op,
    output logic                 md_src,
    output logic                 hi_write,
    output logic                 lo_write,
    output logic                 busy,
    output logic                 stall
);

    localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_CYCLES - 1);
    localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_CYCLES - 1);

    md_state_e           r_state;
    md_state_e           w_state_nxt;
    md_req_t             r_req;
    logic                w_accept;
    logic                w_cnt_zero;
    logic                w_div0_skip;
    logic [MD_CNT_W-1:0] w_load_val;

`ifdef MD_DIV0_SKIP_EN
    assign w_div0_skip = md_is_div(op) && (b_in == '0);
`else
    assign w_div0_skip = 1'b0;
`endif

    assign w_load_val = md_is_div(op) ? DIV_LOAD : MULT_LOAD;

    md_lat_cnt u_lat_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_accept),
        .i_load_val (w_load_val),
        .i_dec      (r_state == MD_RUN),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= MD_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus the same-cycle write strobes to HI/LO.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        hi_write    = 1'b0;
        lo_write    = 1'b0;
        md_src      = 1'b0;
        case (r_state)
            MD_IDLE: begin
                if (start) begin
                    if (!w_div0_skip) begin
                        w_accept    = 1'b1;
                        w_state_nxt = MD_RUN;
                    end
                end else begin
                    hi_write = mt_hi;
                    lo_write = mt_lo;
                end
            end
            MD_RUN: begin
                if (w_cnt_zero) begin
                    hi_write    = 1'b1;
                    lo_write    = 1'b1;
                    md_src      = 1'b1;
                    w_state_nxt = MD_IDLE;
                end
            end
            default: w_state_nxt = MD_IDLE;
        endcase
        if (reset) begin
            hi_write = 1'b0;
            lo_write = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_req <= '0;
        end else if (w_accept) begin
            r_req <= '{a: a_in, b: b_in, op: md_op_e'(op)};
        end
    end

    // Latched operands feed the unit while running so E-stage changes are invisible.
    assign busy  = (r_state == MD_RUN);
    assign a_out = busy ? r_req.a : a_in;
    assign b_out = busy ? r_req.b : b_in;
    assign md_op = busy ? MD_OP_W'(r_req.op) : op;
    assign stall = busy & d_md_use;

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl with a small behavioural HI/LO unit model.
module tb_md_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic        mt_hi;
    logic        mt_lo;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        d_md_use;
    logic [31:0] a_out;
    logic [31:0] b_out;
    logic [1:0]  md_op;
    logic        md_src;
    logic        hi_write;
    logic        lo_write;
    logic        busy;
    logic        stall;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic        p_hw = 1'b0;
    logic        p_lw = 1'b0;
    logic [63:0] p_res = '0;

    md_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .mt_hi    (mt_hi),
        .mt_lo    (mt_lo),
        .a_in     (a_in),
        .b_in     (b_in),
        .d_md_use (d_md_use),
        .a_out    (a_out),
        .b_out    (b_out),
        .md_op    (md_op),
        .md_src   (md_src),
        .hi_write (hi_write),
        .lo_write (lo_write),
        .busy     (busy),
        .stall    (stall)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] md_calc(input logic [1:0] f_op, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        int     q;
        int     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f_op)
            2'b00: return 64'(sa * sb);
            2'b01: return {32'h0, a} * {32'h0, b};
            2'b10: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {32'(r), 32'(q)};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // MD unit model: capture mid-cycle, write HI/LO at the following edge.
    always @(negedge clk) begin
        p_hw  <= hi_write;
        p_lw  <= lo_write;
        p_res <= md_src ? md_calc(md_op, a_out, b_out) : {a_out, a_out};
    end

    always @(posedge clk) begin
        if (p_hw) m_hi <= p_res[63:32];
        if (p_lw) m_lo <= p_res[31:0];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [1:0] o, input logic mh, input logic ml,
                         input logic [31:0] a, input logic [31:0] b, input logic d);
        start    = s;
        op       = o;
        mt_hi    = mh;
        mt_lo    = ml;
        a_in     = a;
        b_in     = b;
        d_md_use = d;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        drive(0, 2'b00, 0, 0, 32'h0, 32'h0, 0);
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        drive(0, 2'b00, 0, 0, 32'h0, 32'h0, 1);
        check("rst_busy", busy, 0);
        check("rst_stall", stall, 0);
        check("rst_hiw", hi_write, 0);
        check("rst_low", lo_write, 0);
        check("rst_src", md_src, 0);
        check("rst_op", md_op, 0);
        tick();

        // mult -2 * 3, mfhi in D from cycle 1, stray mthi during RUN ignored
        drive(1, 2'b00, 0, 0, 32'hFFFF_FFFE, 32'd3, 0);
        check("m1_c0_busy", busy, 0);
        tick();
        for (int c = 1; c <= 5; c++) begin
            drive(0, 2'b10, (c == 2), 0, $urandom, $urandom, 1);
            check("m1_busy", busy, 1);
            check("m1_stall", stall, 1);
            check("m1_hiw", hi_write, (c == 5));
            check("m1_src", md_src, (c == 5));
            check("m1_a", a_out, 32'hFFFF_FFFE);
            check("m1_op", md_op, 2'b00);
            tick();
        end
        drive(0, 2'b00, 0, 0, 32'h0, 32'h0, 1);
        check("m1_c6_busy", busy, 0);
        check("m1_c6_stall", stall, 0);
        check("m1_hi", m_hi, 32'hFFFF_FFFF);
        check("m1_lo", m_lo, 32'hFFFF_FFFA);
        tick();

        // divu 17 / 5 with operands changing during RUN
        drive(1, 2'b11, 0, 0, 32'd17, 32'd5, 0);
        tick();
        for (int c = 1; c <= 10; c++) begin
            drive(0, 2'b00, 0, 0, $urandom, $urandom, 0);
            check("dv_busy", busy, 1);
            check("dv_a", a_out, 32'd17);
            check("dv_b", b_out, 32'd5);
            check("dv_op", md_op, 2'b11);
            check("dv_hiw", hi_write, (c == 10));
            check("dv_low", lo_write, (c == 10));
            tick();
        end
        drive(0, 2'b00, 0, 0, 32'h0, 32'h0, 0);
        check("dv_c11_busy", busy, 0);
        check("dv_lo", m_lo, 32'd3);
        check("dv_hi", m_hi, 32'd2);
        tick();

        // mthi in IDLE
        drive(0, 2'b00, 1, 0, 32'hDEAD_BEEF, 32'h0, 0);
        check("mt_hiw", hi_write, 1);
        check("mt_low", lo_write, 0);
        check("mt_src", md_src, 0);
        check("mt_busy", busy, 0);
        tick();
        drive(0, 2'b00, 0, 0, 32'h0, 32'h0, 0);
        check("mt_hi", m_hi, 32'hDEAD_BEEF);
        check("mt_lo", m_lo, 32'd3);
        check("mt_busy1", busy, 0);
        tick();

        // mult with simultaneous mtlo (dropped), then multu back-to-back at cycle 6
        drive(1, 2'b00, 0, 1, 32'd2, 32'd3, 0);
        check("bb_c0_low", lo_write, 0);
        check("bb_c0_hiw", hi_write, 0);
        tick();
        for (int c = 1; c <= 11; c++) begin
            if (c == 6) drive(1, 2'b01, 0, 0, 32'd7, 32'd8, 0);
            else        drive(0, 2'b00, 0, 0, $urandom, $urandom, 0);
            check("bb_hiw", hi_write, (c == 5 || c == 11));
            check("bb_busy", busy, (c != 6));
            if (c == 6) check("bb_lo1", m_lo, 32'd6);
            tick();
        end
        drive(0, 2'b00, 0, 0, 32'h0, 32'h0, 0);
        check("bb_busy12", busy, 0);
        check("bb_hi", m_hi, 32'd0);
        check("bb_lo", m_lo, 32'd56);
        tick();

        // reset at cycle 3 of a div
        drive(1, 2'b10, 0, 0, 32'd100, 32'd7, 0);
        tick();
        for (int c = 1; c <= 12; c++) begin
            reset = (c == 3);
            drive(0, 2'b00, 0, 0, 32'h0, 32'h0, 0);
            if (c < 3) check("rs_busy", busy, 1);
            if (c > 3) check("rs_busy0", busy, 0);
            check("rs_hiw", hi_write, 0);
            check("rs_low", lo_write, 0);
            tick();
        end
        reset = 1'b0;
        drive(0, 2'b00, 0, 0, 32'h0, 32'h0, 0);
        check("rs_hi", m_hi, 32'd0);
        check("rs_lo", m_lo, 32'd56);
        tick();

        // div by zero
        drive(1, 2'b10, 0, 0, 32'd9, 32'd0, 0);
        tick();
        for (int c = 1; c <= 11; c++) begin
            drive(0, 2'b00, 0, 0, 32'h0, 32'h0, 0);
`ifdef MD_DIV0_SKIP_EN
            check("z_busy", busy, 0);
            check("z_hiw", hi_write, 0);
`else
            check("z_busy", busy, (c <= 10));
            check("z_hiw", hi_write, (c == 10));
`endif
            tick();
        end
        drive(0, 2'b00, 0, 0, 32'h0, 32'h0, 0);
`ifdef MD_DIV0_SKIP_EN
        check("z_hi", m_hi, 32'd0);
        check("z_lo", m_lo, 32'd56);
`else
        check("z_hi", m_hi, 32'd9);
        check("z_lo", m_lo, 32'hFFFF_FFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/md_ctrl.md
# md_ctrl

Multi-cycle sequencer for the HI/LO multiply/divide unit in the execute stage. It accepts mult/multu/div/divu starts and mthi/mtlo writes from E, latches the operands, and drives the unit's operation, source-select and write-enable controls. It models the architectural latency by holding `busy` for a fixed cycle count. It also raises `stall` toward decode for any MD-class instruction (mult/div/mfhi/mflo/mthi/mtlo) issued while an operation is in flight.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu, legal range 1..15.
- `DIV_CYCLES`, default 10: busy cycles for div/divu, legal range 1..15.

- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: E-stage mult/multu/div/divu valid this cycle.
- `op` in 2: 00 mult, 01 multu, 10 div, 11 divu; sampled with `start`.
- `mt_hi` in 1: E-stage mthi valid.
- `mt_lo` in 1: E-stage mtlo valid.
- `a_in` in 32: rs value.
- `b_in` in 32: rt value.
- `d_md_use` in 1: D-stage instruction is MD-class.
- `a_out` out 32: operand A to the MD unit.
- `b_out` out 32: operand B to the MD unit.
- `md_op` out 2: operation select to the MD unit.
- `md_src` out 1: 1 = computed result, 0 = pass `a_out`.
- `hi_write` out 1: HI write enable.
- `lo_write` out 1: LO write enable.
- `busy` out 1: operation in flight.
- `stall` out 1: freeze D and earlier stages.

## Operation
- FSM states: IDLE and RUN.
- Reset values: state IDLE, counter 0, `a_q`/`b_q`/`op_q` 0, `busy` 0, `stall` 0, `hi_write`/`lo_write` 0, `md_src` 0, `md_op` 00.
- `start` accepted in IDLE:
  - Latch `a_in`, `b_in` and `op`.
  - Load the counter with `MULT_CYCLES-1` (op[1]=0) or `DIV_CYCLES-1` (op[1]=1).
  - Move to RUN.
- RUN: decrement the counter each cycle. When the counter reaches 0:
  - Assert `hi_write`, `lo_write` and `md_src=1` for exactly that cycle.
  - Return to IDLE.
- Outputs `busy` is 1 exactly when the state is RUN.
- Operand mux: `a_out`/`b_out`/`md_op` = latched values in RUN, else `a_in`/`b_in`/`op`.
- mthi/mtlo in IDLE with no `start`:
  - `hi_write=mt_hi` and `lo_write=mt_lo` combinationally in the same cycle.
  - `md_src=0`, so the unit writes `a_in`.
- `stall = busy & d_md_use` (combinational).
- Simultaneous events:
  - `start` together with `mt_hi`/`mt_lo`: `start` wins and the mt write is dropped.
  - `start`, `mt_hi` or `mt_lo` while in RUN: ignored, because the `stall` protocol makes this unreachable.
- Reset in RUN: abort to IDLE in the next cycle with no commit; HI/LO are unchanged by this block.

## Timing
- `start` at cycle 0, N = configured cycles:
  - `busy` is 1 in cycles 1..N.
  - The commit pulse is in cycle N; HI/LO hold the new values from cycle N+1.
  - `busy` is 0 in cycle N+1.
- Back-to-back: a new `start` is accepted in cycle N+1, giving zero dead cycles.
- mthi/mtlo: a write in cycle 0 is visible in HI/LO in cycle 1.
- Latency is data-independent: the count depends only on `op[1]`.

## Configuration
- `MD_DIV0_SKIP_EN` defined:
  - div/divu accepted with `b_in==0` does not enter RUN.
  - `busy` stays 0, no write enables are asserted, and HI/LO are preserved.
- Not defined: division by zero follows the normal DIV_CYCLES path and commits whatever the MD unit produces.

## Structure
- Shared package `md_pkg`:
  - op encodings `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`.
  - state encodings `MD_IDLE`, `MD_RUN`.
  - default cycle constants.
- One sub-module, `md_lat_cnt`: a 4-bit loadable down-counter with a `zero` flag.

## Test plan
- mult with `a_in=32'hFFFF_FFFE` (-2), `b_in=3`, then mfhi in D at cycle 1:
  - `stall` is 1 in cycles 1..5 and `busy` falls in cycle 6.
  - HI=`FFFF_FFFF` and LO=`FFFF_FFFA` from cycle 6.
- divu with `a_in=17`, `b_in=5`, changing `a_in`/`b_in` every cycle during RUN:
  - Operands stay latched.
  - LO=3 and HI=2 after 10 busy cycles.
- mthi with `a_in=32'hDEAD_BEEF` in IDLE:
  - `hi_write=1`, `lo_write=0`, `md_src=0`.
  - HI=`DEAD_BEEF` next cycle, no `busy`.
- mult followed by mult issued in cycle 6:
  - The second mult is accepted with no gap.
  - Two separate commit pulses occur, in cycles 5 and 11.
- `reset` at cycle 3 of a div:
  - `busy=0` in cycle 4 and no write enable is ever asserted.
  - HI/LO keep their prior values.
- div with `b_in=0`:
  - With `MD_DIV0_SKIP_EN`: `busy` never rises and HI/LO are unchanged.
  - Without it: a commit pulse occurs at cycle 10.
